// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central hold / jump-shadow controller for an in-order pipeline.
//
//   Each of NHLD requesters can hold the pipeline. A hold request pulse sets
//   that requester's flag, and a release pulse clears it. A release takes
//   effect combinationally in the same cycle.
//
//   A jump from execute is forwarded to fetch with zero latency. The jump
//   clears every hold and opens a kill shadow of JMP_LAT cycles, during which
//   fetched instructions are invalidated.
//
//   When HLD_TMO > 0, a hold that stays set for HLD_TMO cycles is force-released,
//   and the release is flagged with a one-cycle hld_tmo pulse.
//
//   Request semantics: every request input is a single-cycle pulse sampled on
//   the rising edge of clk. There is no back-pressure, and each pulse is
//   consumed in the cycle it is presented.
//
// Ports
//   clk      in   single clock, rising edge
//   rstn     in   asynchronous active-low reset
//   hld_req  in   [NHLD] per-source hold request pulse
//   run_req  in   [NHLD] per-source release request pulse
//   jmp_req  in   jump request pulse from execute
//   hld      out  pipeline hold (OR of hld_vec)
//   hld_vec  out  [NHLD] effective per-source hold
//   jmp      out  jump strobe to fetch (= jmp_req)
//   kill     out  invalidate fetched instruction (jump shadow active)
//   hld_tmo  out  one-cycle pulse: hold force-released by timeout
module pipeline_hazard_ctrl #(
  parameter int NHLD    = 2,
  parameter int JMP_LAT = 2,
  parameter int HLD_TMO = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NHLD-1:0] hld_req,
  input  logic [NHLD-1:0] run_req,
  input  logic            jmp_req,
  output logic            hld,
  output logic [NHLD-1:0] hld_vec,
  output logic            jmp,
  output logic            kill,
  output logic            hld_tmo
);

  localparam int KW = $clog2(JMP_LAT + 1);
  localparam logic [KW-1:0] KILL_LOAD = KW'(JMP_LAT);

  logic [NHLD-1:0] flag_q;
  logic [NHLD-1:0] flag_d;
  logic [KW-1:0]   kill_q;
  logic [KW-1:0]   kill_d;
  logic            tmo_fire;
  logic            tmo_q;

  // Hold flags. A set request wins over a release in the same cycle.
  // A jump or a timeout overrides both, and set requests arriving with the
  // jump are dropped.
  always_comb begin
    flag_d = (flag_q & ~run_req) | hld_req;
    if (jmp_req || tmo_fire) begin
      flag_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flag_q <= '0;
    end else begin
      flag_q <= flag_d;
    end
  end

  // Kill shadow. A jump always reloads the full length, so back-to-back
  // jumps restart the shadow rather than extending it. The counter keeps
  // running while the pipeline is held.
  always_comb begin
    kill_d = kill_q;
    if (jmp_req) begin
      kill_d = KILL_LOAD;
    end else if (kill_q != '0) begin
      kill_d = kill_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kill_q <= '0;
    end else begin
      kill_q <= kill_d;
    end
  end

  // Hold timeout. The counter holds the number of completed cycles with at
  // least one flag set. It fires on its last value, so the pipeline is held
  // for exactly HLD_TMO cycles before the forced release.
  generate
    if (HLD_TMO > 0) begin : g_tmo
      localparam int TW = $clog2(HLD_TMO + 1);
      localparam logic [TW-1:0] TMO_LAST = TW'(HLD_TMO - 1);

      logic [TW-1:0] cnt_q;
      logic [TW-1:0] cnt_d;

      always_comb begin
        tmo_fire = (|flag_q) && (cnt_q == TMO_LAST) && !jmp_req;
        cnt_d    = cnt_q + 1'b1;
        if (!(|flag_q) || jmp_req || tmo_fire) begin
          cnt_d = '0;
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt_q <= '0;
          tmo_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          tmo_q <= tmo_fire;
        end
      end
    end else begin : g_no_tmo
      assign tmo_fire = 1'b0;
      assign tmo_q    = 1'b0;
    end
  endgenerate

  // A release or a jump drops the hold in the same cycle it is requested.
  assign hld_vec = flag_q & ~run_req & ~{NHLD{jmp_req}};
  assign hld     = |hld_vec;
  assign jmp     = jmp_req;
  assign kill    = (kill_q != '0);
  assign hld_tmo = tmo_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter NHLD, default 2, number of independent hold requesters (1..8).
REQ-002 SHALL have parameter JMP_LAT, default 2, kill-shadow length in cycles after a jump (1..15).
REQ-003 SHALL have parameter HLD_TMO, default 16, hold timeout in cycles (0 = timeout disabled, else 2..255).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port hld_req  input  NHLD  per-source hold request pulse.
REQ-007 SHALL have port run_req  input  NHLD  per-source release request pulse.
REQ-008 SHALL have port jmp_req  input  1  jump request pulse from execute stage.
REQ-009 SHALL have port hld  output  1  pipeline hold, OR of effective per-source holds.
REQ-010 SHALL have port hld_vec  output  NHLD  effective per-source hold.
REQ-011 SHALL have port jmp  output  1  jump strobe to fetch.
REQ-012 SHALL have port kill  output  1  invalidate fetched instruction (jump shadow).
REQ-013 SHALL have port hld_tmo  output  1  one-cycle pulse, hold forcibly released by timeout.

Function
REQ-014 SHALL keep one hold flag per source i: hld_req[i] sets it at next edge, run_req[i] clears it at next edge; both in same cycle -> set wins.
REQ-015 SHALL drive hld_vec[i] = flag[i] & ~run_req[i] & ~jmp_req combinationally (same-cycle release, no added latency).
REQ-016 SHALL drive hld = |hld_vec.
REQ-017 SHALL drive jmp = jmp_req combinationally, zero latency.
REQ-018 SHALL, on jmp_req, clear all hold flags at next edge; hld_req arriving in the jmp_req cycle is ignored.
REQ-019 SHALL keep a kill counter: jmp_req loads JMP_LAT at next edge; counter decrements by 1 per cycle while nonzero; kill = (counter != 0).
REQ-020 SHALL reload the kill counter to JMP_LAT when jmp_req arrives while counter nonzero (shadow restarts, no accumulation).
REQ-021 SHALL keep kill counting regardless of hld (jump shadow not frozen by hold).
REQ-022 SHALL, when HLD_TMO>0, keep a timeout counter that increments each cycle any hold flag is set, and clears to 0 in any cycle where no flag is set at the edge.
REQ-023 SHALL, when the timeout counter equals HLD_TMO-1 with a flag still set and no jmp_req, clear all flags and the counter at next edge and pulse hld_tmo high for exactly the following cycle.
REQ-024 SHALL give jmp_req priority over timeout in the same cycle: flags cleared, hld_tmo not asserted.
REQ-025 SHALL, when HLD_TMO=0, hold hld_tmo at 0 and never force-release.
REQ-026 SHALL size counters minimally: kill counter $clog2(JMP_LAT+1) bits, timeout counter $clog2(HLD_TMO+1) bits; no wrap-around permitted.

Reset
REQ-027 SHALL, while rstn=0, asynchronously clear all hold flags, kill counter, timeout counter and hld_tmo register; hld, hld_vec, kill, hld_tmo read 0; jmp follows jmp_req.
REQ-028 SHALL, on rstn assertion mid-hold or mid-shadow, abandon the operation with no pulse emitted after release.
REQ-029 SHALL accept requests on the first rising edge after rstn deasserts.

Verification (defaults NHLD=2, JMP_LAT=2, HLD_TMO=16)
REQ-030 SHALL cover: hld_req=01 at cycle 0, run_req=01 at cycle 3 -> hld=1 cycles 1-2, hld=0 at cycle 3 (same cycle), flag clear cycle 4.
REQ-031 SHALL cover: hld_req=01 and run_req=01 same cycle with flag clear -> hld_vec=01 next cycle.
REQ-032 SHALL cover: hld_req=11 cycle 0, run_req=01 cycle 2 -> hld_vec=10, hld=1 from cycle 2.
REQ-033 SHALL cover: jmp_req at cycle 5 while hld_vec=01 -> jmp=1 and hld=0 at cycle 5, kill=1 cycles 6-7, 0 at 8; second jmp_req at cycle 7 -> kill=1 through cycle 9.
REQ-034 SHALL cover: hld_req=10 at cycle 0, no release -> hld=1 cycles 1-16, hld_tmo=1 at cycle 17 only, hld=0 from cycle 17.
REQ-035 SHALL cover: rstn low at cycle 3 during hold and kill shadow -> all outputs except jmp read 0 immediately, no hld_tmo after reset release.
